// File: rtl/dct_coef_ctrl.sv
// Sequencer for one 2-D DCT coefficient: walks the 8x8 pixel block, multiplies by the cosine LUT,
// and accumulates. Optional macro DCT_COEF_ROUND_EN rounds the result to coef = (acc + 128) >>> 8.
module dct_coef_ctrl (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [2:0]         k1,
  input  logic [2:0]         k2,
  output logic [5:0]         pix_addr,
  input  logic signed [7:0]  pix_rd_data,
  output logic [2:0]         lut_k1,
  output logic [2:0]         lut_k2,
  output logic [2:0]         lut_n1,
  output logic [2:0]         lut_n2,
  input  logic signed [31:0] lut_cos,
  output logic signed [31:0] coef,
  output logic               coef_valid,
  input  logic               coef_ready,
  output logic               busy
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StOut} state_e;

  state_e             state_q, state_d;
  logic [5:0]         idx_q, idx_d;
  logic signed [31:0] acc_q, acc_d;
  logic signed [31:0] coef_q, coef_d;
  logic [2:0]         k1_q, k1_d, k2_q, k2_d;
  // Operand-stage index and valid: the LUT indices line up with the registered pixel read.
  logic [5:0]         stage_idx_q, stage_idx_d;
  logic               stage_vld_q, stage_vld_d;

  logic [31:0]        pix_ext;
  logic [31:0]        prod;

  // Only the low 32 bits are kept, so the sign-extended product is identical signed or unsigned.
  assign pix_ext = {{24{pix_rd_data[7]}}, pix_rd_data};
  assign prod    = pix_ext * lut_cos;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    coef_d      = coef_q;
    k1_d        = k1_q;
    k2_d        = k2_q;
    stage_idx_d = 6'd0;
    stage_vld_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d = StRun;
          idx_d   = 6'd0;
          acc_d   = 32'sd0;
          k1_d    = k1;
          k2_d    = k2;
        end
      end

      StRun: begin
        if (abort) begin
          state_d = StIdle;
          idx_d   = 6'd0;
        end else begin
          stage_idx_d = idx_q;
          stage_vld_d = 1'b1;
          idx_d       = idx_q + 6'd1;
          if (stage_vld_q) begin
            acc_d = $signed(acc_q + prod);
          end
          if (idx_q == 6'd63) begin
            state_d = StDrain;
          end
        end
      end

      StDrain: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          acc_d   = $signed(acc_q + prod);
          state_d = StOut;
`ifdef DCT_COEF_ROUND_EN
          coef_d  = $signed(acc_d + 32'd128) >>> 8;
`else
          coef_d  = acc_d;
`endif
        end
      end

      StOut: begin
        // A ready coinciding with abort still completes the transfer; both end in idle.
        if (coef_ready || abort) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= 6'd0;
      acc_q       <= 32'sd0;
      coef_q      <= 32'sd0;
      k1_q        <= 3'd0;
      k2_q        <= 3'd0;
      stage_idx_q <= 6'd0;
      stage_vld_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      coef_q      <= coef_d;
      k1_q        <= k1_d;
      k2_q        <= k2_d;
      stage_idx_q <= stage_idx_d;
      stage_vld_q <= stage_vld_d;
    end
  end

  assign pix_addr   = (state_q == StRun) ? idx_q : 6'd0;
  assign lut_k1     = k1_q;
  assign lut_k2     = k2_q;
  assign lut_n1     = stage_idx_q[5:3];
  assign lut_n2     = stage_idx_q[2:0];
  assign coef       = coef_q;
  assign coef_valid = (state_q == StOut);
  assign busy       = (state_q != StIdle);

endmodule
